// File: rtl/reflet_timer_multi.sv
// reflet_timer_multi: multi-channel timer on the 8-bit peripheral bus.
// A shared 8-bit prescaler ticks CHANNELS independent WIDTH-bit up-counters.
// Each channel fires when its counter matches its compare value, and the
// maskable pending flags merge into a single interrupt line.
module reflet_timer_multi #(
  parameter int base_addr_size = 16,
  parameter int base_addr      = 0,
  parameter int CHANNELS       = 2,
  parameter int WIDTH          = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  output logic                      interrupt,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [7:0]                data_in,
  output logic [7:0]                data_out
);

  localparam int          SPAN  = 8 + 8 * CHANNELS;
  localparam int          BYTES = WIDTH / 8;
  localparam logic [31:0] LO    = 32'(base_addr);
  localparam logic [31:0] HI    = 32'(base_addr + SPAN);

  logic [7:0]          prescale;
  logic [7:0]          pcnt;
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] mask;
  logic [CHANNELS-1:0] run;
  logic [CHANNELS-1:0] periodic;
  logic [CHANNELS-1:0] fire;
  logic [CHANNELS-1:0] clr;
  logic [WIDTH-1:0]    compare [CHANNELS];
  logic [WIDTH-1:0]    cnt     [CHANNELS];

  logic [31:0] addr32;
  logic [31:0] off;
  logic [31:0] ch_idx;
  logic [31:0] sub;
  logic        sel;
  logic        wr;
  logic        tick;

  // Address decode: offsets are 32-bit so comparisons with loop indices stay width-clean
  always_comb begin
    addr32 = 32'(addr);
    sel    = enable && (addr32 >= LO) && (addr32 < HI);
    off    = addr32 - LO;
    ch_idx = (off - 32'd8) >> 3;
    sub    = off & 32'd7;
    wr     = sel && write_en;
  end

  assign tick = (pcnt == prescale);

  // Channel match detection on the shared tick, plus the write-1-clear mask for STATUS
  always_comb begin
    fire = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      fire[c] = tick && run[c] && (cnt[c] == compare[c]);
    end
    clr = (wr && off == 32'd1) ? data_in[CHANNELS-1:0] : '0;
  end

  // Prescaler: counts 0..prescale, restarting whenever PRESCALE is written
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= 8'd0;
      pcnt     <= 8'd0;
    end else if (wr && off == 32'd0) begin
      prescale <= data_in;
      pcnt     <= 8'd0;
    end else if (tick) begin
      pcnt <= 8'd0;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

  // Pending flags and mask; a new fire beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~clr) | fire;
      if (wr && off == 32'd2) begin
        mask <= data_in[CHANNELS-1:0];
      end
    end
  end

  // Per-channel counting and register writes; a CTRL write overrides a same-cycle one-shot stop
  always_ff @(posedge clk) begin
    if (reset) begin
      run      <= '0;
      periodic <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c]     <= '0;
        compare[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (tick && run[c]) begin
          if (cnt[c] == compare[c]) begin
            cnt[c] <= '0;
            if (!periodic[c]) begin
              run[c] <= 1'b0;
            end
          end else begin
            cnt[c] <= cnt[c] + WIDTH'(1);
          end
        end
        if (wr && off >= 32'd8 && ch_idx == 32'(c)) begin
          if (sub == 32'd0) begin
            run[c]      <= data_in[0];
            periodic[c] <= data_in[1];
            cnt[c]      <= '0;
          end
          for (int k = 0; k < BYTES; k++) begin
            if (sub == 32'(k + 1)) begin
              compare[c][8*k +: 8] <= data_in;
            end
          end
        end
      end
    end
  end

  // Read mux: anything unselected, reserved or beyond WIDTH reads as zero
  always_comb begin
    data_out = 8'd0;
    if (sel) begin
      if (off == 32'd0) begin
        data_out = prescale;
      end else if (off == 32'd1) begin
        data_out = 8'(pending);
      end else if (off == 32'd2) begin
        data_out = 8'(mask);
      end else if (off >= 32'd8) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (ch_idx == 32'(c)) begin
            if (sub == 32'd0) begin
              data_out = {6'd0, periodic[c], run[c]};
            end
            for (int k = 0; k < BYTES; k++) begin
              if (sub == 32'(k + 1)) begin
                data_out = compare[c][8*k +: 8];
              end
            end
          end
        end
      end
    end
  end

  assign interrupt = |(pending & mask);

endmodule

// File: tb/tb_reflet_timer_multi.sv
// tb_reflet_timer_multi: directed scenarios plus randomized bus traffic,
// compared cycle by cycle against a behavioural model of the timer.
module tb_reflet_timer_multi;

  localparam int BASE = 32;
  localparam int CH   = 2;
  localparam int SPAN = 8 + 8 * CH;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        write_en;
  logic        interrupt;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;

  int total = 0;
  int bad   = 0;

  int m_prescale, m_pcnt, m_mask, m_pending;
  int m_run [CH];
  int m_per [CH];
  int m_cmp [CH];
  int m_cnt [CH];

  reflet_timer_multi #(
    .base_addr_size(16),
    .base_addr(BASE),
    .CHANNELS(CH),
    .WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .interrupt(interrupt),
    .addr(addr),
    .write_en(write_en),
    .data_in(data_in),
    .data_out(data_out)
  );

  // Free-running clock, 10 time units per period
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prescale = 0; m_pcnt = 0; m_mask = 0; m_pending = 0;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0; m_per[c] = 0; m_cmp[c] = 0; m_cnt[c] = 0;
    end
  endtask

  function automatic int model_read(input logic en, input logic [15:0] a);
    int o, c, r;
    if (!en || int'(a) < BASE || int'(a) >= BASE + SPAN) return 0;
    o = int'(a) - BASE;
    if (o == 0) return m_prescale;
    if (o == 1) return m_pending;
    if (o == 2) return m_mask;
    if (o < 8) return 0;
    c = (o - 8) / 8;
    r = (o - 8) % 8;
    if (r == 0) return m_run[c] + 2 * m_per[c];
    if (r == 1) return m_cmp[c] % 256;
    if (r == 2) return m_cmp[c] / 256;
    return 0;
  endfunction

  function automatic int model_irq();
    return ((m_pending & m_mask) != 0) ? 1 : 0;
  endfunction

  // One clock edge of the timer as described by its rules, using pre-edge state
  task automatic model_step(input logic en, input logic we, input logic [15:0] a, input logic [7:0] d);
    int tick, set, clr, o, c, r;
    tick = (m_pcnt == m_prescale) ? 1 : 0;
    set  = 0;
    clr  = 0;
    for (int i = 0; i < CH; i++) begin
      if (tick != 0 && m_run[i] != 0) begin
        if (m_cnt[i] == m_cmp[i]) begin
          m_cnt[i] = 0;
          set = set | (1 << i);
          if (m_per[i] == 0) m_run[i] = 0;
        end else begin
          m_cnt[i] = (m_cnt[i] + 1) % 65536;
        end
      end
    end
    m_pcnt = (tick != 0) ? 0 : m_pcnt + 1;
    if (en && we && int'(a) >= BASE && int'(a) < BASE + SPAN) begin
      o = int'(a) - BASE;
      if (o == 0) begin
        m_prescale = int'(d);
        m_pcnt = 0;
      end else if (o == 1) begin
        clr = int'(d) & 3;
      end else if (o == 2) begin
        m_mask = int'(d) & 3;
      end else if (o >= 8) begin
        c = (o - 8) / 8;
        r = (o - 8) % 8;
        if (r == 0) begin
          m_run[c] = int'(d) & 1;
          m_per[c] = (int'(d) >> 1) & 1;
          m_cnt[c] = 0;
        end else if (r == 1) begin
          m_cmp[c] = (m_cmp[c] & 'hFF00) | int'(d);
        end else if (r == 2) begin
          m_cmp[c] = (m_cmp[c] & 'h00FF) | (int'(d) << 8);
        end
      end
    end
    m_pending = (m_pending & ~clr) | set;
  endtask

  // Drive one bus cycle at the falling edge, check outputs, then advance DUT and model together
  task automatic applyStimulus(input logic en, input logic we, input logic [15:0] a, input logic [7:0] d);
    enable = en; write_en = we; addr = a; data_in = d;
    #1;
    checkOutput("data_out", 32'(data_out), model_read(en, a));
    checkOutput("interrupt", 32'(interrupt), model_irq());
    @(posedge clk);
    model_step(en, we, a, d);
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    applyStimulus(1'b1, 1'b1, 16'(a), 8'(d));
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 16'(BASE + 1), 8'd0);
  endtask

  task automatic readExpect(input string tag, input int a, input int exp);
    applyStimulus(1'b1, 1'b0, 16'(a), 8'd0);
    checkOutput(tag, 32'(data_out), exp);
  endtask

  task automatic doReset();
    reset = 1'b1; enable = 1'b1; write_en = 1'b0; addr = 16'(BASE); data_in = 8'd0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n, m, found;
    logic en, we;
    logic [15:0] a;
    logic [7:0] d;

    reset = 1'b1; enable = 1'b0; write_en = 1'b0; addr = '0; data_in = '0;
    @(negedge clk);
    doReset();

    $display("[TB] reset and readback");
    checkOutput("reset_irq", 32'(interrupt), 0);
    for (int i = BASE - 1; i <= BASE + SPAN; i++) applyStimulus(1'b1, 1'b0, 16'(i), 8'd0);
    wr(BASE + 9, 'h34); wr(BASE + 10, 'h12); wr(BASE + 2, 'h03); wr(BASE + 11, 'h55);
    readExpect("cmp0_b0", BASE + 9, 'h34);
    readExpect("cmp0_b1", BASE + 10, 'h12);
    readExpect("cmp0_b2", BASE + 11, 0);
    readExpect("cmp0_b3", BASE + 12, 0);
    readExpect("mask_rb", BASE + 2, 'h03);

    $display("[TB] periodic channel 0");
    doReset();
    wr(BASE + 0, 2); wr(BASE + 9, 4); wr(BASE + 2, 1); wr(BASE + 8, 3);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (interrupt) begin n = i; break; end
    end
    checkOutput("periodic_first", n, 15);
    wr(BASE + 1, 1);
    checkOutput("irq_cleared", 32'(interrupt), 0);
    m = 0;
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (interrupt) begin m = i; break; end
    end
    checkOutput("periodic_refire", m + 1, 15);

    $display("[TB] one-shot channel 1");
    doReset();
    wr(BASE + 2, 2); wr(BASE + 17, 3); wr(BASE + 16, 1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      idle();
      if (interrupt) begin n = i; break; end
    end
    checkOutput("oneshot_fire", n, 4);
    readExpect("oneshot_run", BASE + 16, 0);
    wr(BASE + 1, 2);
    for (int i = 0; i < 20; i++) idle();
    checkOutput("oneshot_quiet", 32'(interrupt), 0);

    $display("[TB] masking and clear/set collision");
    doReset();
    wr(BASE + 9, 5); wr(BASE + 17, 9); wr(BASE + 2, 2); wr(BASE + 8, 3); wr(BASE + 16, 3);
    for (int i = 0; i < 40; i++) idle();
    readExpect("both_pending", BASE + 1, 3);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (m_pcnt == m_prescale && m_run[1] != 0 && m_cnt[1] == m_cmp[1]) begin found = 1; break; end
      idle();
    end
    checkOutput("collision_setup", found, 1);
    wr(BASE + 1, 2);
    checkOutput("collision_irq", 32'(interrupt), 1);

    $display("[TB] decode and enable gating");
    wr(BASE - 1, 'hFF); wr(BASE + SPAN, 'hFF);
    readExpect("decode_mask", BASE + 2, 2);
    readExpect("decode_below", BASE - 1, 0);
    applyStimulus(1'b0, 1'b1, 16'(BASE + 8), 8'd0);
    readExpect("gated_ctrl", BASE + 8, 3);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 16'(BASE + 1), 8'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 9) != 0);
      we = ($urandom_range(0, 4) == 0);
      a  = 16'(BASE - 2 + int'($urandom_range(0, SPAN + 3)));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      applyStimulus(en, we, a, d);
    end

    $display("[TB] reset mid-count");
    doReset();
    wr(BASE + 9, 5); wr(BASE + 2, 1); wr(BASE + 8, 3);
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_cnt[0] == 3 && interrupt) begin found = 1; break; end
      idle();
    end
    checkOutput("midreset_setup", found, 1);
    doReset();
    checkOutput("midreset_irq", 32'(interrupt), 0);
    readExpect("midreset_ctrl", BASE + 8, 0);
    readExpect("midreset_cmp", BASE + 9, 0);
    for (int i = 0; i < 20; i++) idle();
    checkOutput("midreset_quiet", 32'(interrupt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
